// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the STPU pipeline control unit: exception codes,
// FSM state encoding, reset/zero constants and the redirect-PC decoder.
package pipe_ctrl_pkg;

  // Reset is active-low: the reset input equals RST_ENABLE while asserted.
  localparam logic        RST_ENABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  // Committed exception codes as seen at the MEM stage.
  localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
  localparam logic [31:0] EXC_INTR    = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_INST    = 32'h0000_000a;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  // Flush-hold FSM states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Map an exception code to its redirect target. Interrupts go to the
  // interrupt vector, eret returns to EPC, every other nonzero code
  // (syscall, invalid instruction, overflow, trap, unknown) goes to the
  // general vector.
  function automatic logic [31:0] decode_pc(
    input logic [31:0] code,
    input logic [31:0] epc,
    input logic [31:0] vec_intr,
    input logic [31:0] vec_gen
  );
    logic [31:0] target;
    case (code)
      EXC_INTR: target = vec_intr;
      EXC_ERET: target = epc;
      default:  target = vec_gen;
    endcase
    return target;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating event counter: counts up on inc, sticks at all-ones, and
// clears synchronously on clr or asynchronously on reset.
module sat_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = '1;

  // Count register: clear beats increment, increment stops at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && count != MAX) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples
      // pre-edge values; blocking here would create order-dependent races.
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: prefix stall merge, exception redirect decode,
// flush-hold FSM, stall watchdog and stall/flush event counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          NUM_STAGES    = 6,
  parameter int          FLUSH_CYCLES  = 1,
  parameter int          STALL_TIMEOUT = 1024,
  parameter logic [31:0] VEC_INTR      = 32'h0000_0020,
  parameter logic [31:0] VEC_GEN       = 32'h0000_0040,
  parameter int          CNT_W         = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stallreq_i,
  input  logic [31:0]           excepttype_i,
  input  logic [31:0]           cp0_epc_i,
  input  logic                  wdog_clr_i,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic                  flush_o,
  output logic [31:0]           new_pc_o,
  output logic                  wdog_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  localparam int HOLD_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam int RUN_W  = $clog2(STALL_TIMEOUT + 1);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(FLUSH_CYCLES - 1);
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(STALL_TIMEOUT);

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [31:0]       pc_q, pc_d;
  logic              accept;

  logic [RUN_W-1:0]  run_q, run_d;
  logic              wdog_q, wdog_d;

  // FSM, hold counter and registered redirect target.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      pc_q    <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state and output decode; outputs are forced low while in reset.
  always_comb begin
    logic any_below;
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    hold_d    = hold_q;
    pc_d      = pc_q;
    accept    = 1'b0;
    flush_o   = 1'b0;
    new_pc_o  = ZERO_WORD;
    stall_o   = '0;
    any_below = 1'b0;

    if (rst != RST_ENABLE) begin
      case (state_q)
        ST_IDLE: begin
          if (excepttype_i != EXC_NONE) begin
            // Exception wins over any stall request in the same cycle.
            accept   = 1'b1;
            flush_o  = 1'b1;
            new_pc_o = decode_pc(excepttype_i, cp0_epc_i, VEC_INTR, VEC_GEN);
            pc_d     = new_pc_o;
            if (FLUSH_CYCLES > 1) begin
              state_d = ST_FLUSH;
              hold_d  = HOLD_LOAD;
            end
          end else begin
            // A request from stage k stalls every stage at or before k.
            for (int i = NUM_STAGES - 1; i >= 0; i--) begin
              any_below  = any_below | stallreq_i[i];
              stall_o[i] = any_below;
            end
          end
        end

        ST_FLUSH: begin
          // Hold the flush; new exceptions and stall requests are ignored.
          flush_o  = 1'b1;
          new_pc_o = pc_q;
          if (hold_q <= HOLD_W'(1)) begin
            state_d = ST_IDLE;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Watchdog next state: clear wins, otherwise count the stall run and
  // raise the sticky flag once the run reaches the timeout.
  always_comb begin
    run_d  = run_q;
    wdog_d = wdog_q;
    if (wdog_clr_i) begin
      run_d  = '0;
      wdog_d = 1'b0;
    end else if (stall_o[0]) begin
      if (run_q != RUN_MAX) begin
        run_d = run_q + 1'b1;
      end
      if (run_d == RUN_MAX) begin
        wdog_d = 1'b1;
      end
    end else begin
      run_d = '0;
    end
  end

  // Watchdog run counter and sticky flag.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      run_q  <= '0;
      wdog_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      wdog_q <= wdog_d;
    end
  end

  assign wdog_o = wdog_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_o[0]),
    .clr   (1'b0),
    .count (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept),
    .clr   (1'b0),
    .count (flush_cnt_o)
  );

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit for the STPU core: merges per-stage stall requests into a prefix stall vector, decodes the committed exception type into a redirect PC, and drives a pipeline flush held for a configurable number of cycles. It sits beside the datapath, fed by ID/EX stall requests, the MEM-stage exception type and CP0 EPC, and drives the stage registers and the PC unit. It adds a flush-hold FSM, a stall watchdog and stall/flush event counters.

## Interface
- NUM_STAGES, 6, pipeline stages controlled (bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, ...); minimum 2
- FLUSH_CYCLES, 1, cycles flush_o stays high per exception; minimum 1
- STALL_TIMEOUT, 1024, consecutive stall cycles before watchdog fires; minimum 2
- VEC_INTR, 32'h00000020, interrupt vector
- VEC_GEN, 32'h00000040, general exception vector
- CNT_W, 32, width of event counters
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- stallreq_i  in  NUM_STAGES  per-stage stall request, bit i from stage i
- excepttype_i  in  32  committed exception code, 0 = none
- cp0_epc_i  in  32  EPC for eret
- wdog_clr_i  in  1  clears the sticky watchdog flag
- stall_o  out  NUM_STAGES  stall enables
- flush_o  out  1  pipeline flush
- new_pc_o  out  32  redirect target, valid while flush_o = 1
- wdog_o  out  1  sticky stall-timeout flag
- stall_cnt_o  out  CNT_W  saturating count of cycles with stall_o[0] = 1
- flush_cnt_o  out  CNT_W  saturating count of exceptions accepted

## Operation
- FSM states: IDLE, FLUSH. Reset enters IDLE.
- Exception acceptance: in IDLE, a nonzero excepttype_i is accepted in the same cycle. flush_o = 1 combinationally, stall_o = 0, and new_pc_o is decoded as follows.
  - 0x01: VEC_INTR.
  - 0x0e: cp0_epc_i.
  - 0x08, 0x0a, 0x0c, 0x0d and any other nonzero code: VEC_GEN.
- On acceptance, the decoded PC is registered and flush_cnt increments.
  - If FLUSH_CYCLES > 1, the FSM moves to FLUSH, and the hold counter loads FLUSH_CYCLES-1.
  - If FLUSH_CYCLES = 1, the FSM stays in IDLE.
- FLUSH state:
  - flush_o = 1, new_pc_o = registered PC, stall_o = 0.
  - excepttype_i and stallreq_i are ignored; no new exception is accepted.
  - The counter decrements each cycle; the FSM returns to IDLE when it reaches 1.
- Stall merge (IDLE, no exception): stall_o[i] = OR of stallreq_i[NUM_STAGES-1:i], so a request from stage k stalls stages 0..k. new_pc_o = 0 and flush_o = 0.
- Priority: exception over stall. An exception and a stall request in the same IDLE cycle give stall_o = 0.
- Watchdog:
  - A run counter increments each cycle stall_o[0] = 1 and clears when stall_o[0] = 0.
  - When the counter reaches STALL_TIMEOUT, wdog_o sets and stays set.
  - The counter saturates at STALL_TIMEOUT.
  - wdog_clr_i clears wdog_o and the run counter; clear wins over a same-cycle set.
- Event counters saturate at all-ones and never wrap. They clear only on reset.

## Timing
- Reset values (asynchronous, while rst = 0):
  - stall_o = 0, flush_o = 0, new_pc_o = 0, wdog_o = 0, both counters = 0, FSM = IDLE.
- Reset asserted mid-FLUSH aborts the hold immediately. The first cycle after reset release is IDLE.
- Combinational paths, all zero latency from input to output in IDLE:
  - excepttype_i to flush_o and new_pc_o.
  - cp0_epc_i to new_pc_o.
  - stallreq_i to stall_o.
- Flush duration: flush_o is high for exactly FLUSH_CYCLES consecutive cycles per accepted exception. The first cycle is the acceptance cycle.
- Back-to-back exceptions: a nonzero excepttype_i on the cycle after FLUSH exits is accepted normally.
- Counters and wdog_o update on the rising edge after the qualifying cycle.

## Structure
- Shared package or Defines.vh entries:
  - Exception code constants: EXC_INTR 0x01, EXC_SYSCALL 0x08, EXC_INST 0x0a, EXC_OV 0x0c, EXC_TRAP 0x0d, EXC_ERET 0x0e.
  - FSM state encodings.
  - Existing `RstEnable`/`ZeroWord` macros, reinterpreted for active-low reset.
- One sub-module: sat_counter (parameter W; inc, clr, count). It is instantiated for stall_cnt and flush_cnt.

## Test plan
- stallreq_i = 6'b001000 (EX) -> stall_o = 6'b001111. stallreq_i = 6'b000100 (ID) -> 6'b000111. Both set -> 6'b001111.
- FLUSH_CYCLES = 3; excepttype_i = 0x08 for one cycle with stallreq_i = 6'b001000 -> flush_o high for 3 cycles, new_pc_o = 0x40 throughout, stall_o = 0, flush_cnt_o = 1.
- excepttype_i = 0x0e, cp0_epc_i = 0x0000_1234 -> new_pc_o = 0x1234. excepttype_i = 0x01 -> 0x20. excepttype_i = 0x05 (unknown) -> 0x40 with flush.
- FLUSH_CYCLES = 4; second exception (0x01) two cycles into the hold -> ignored, new_pc_o stays at the first target, flush_cnt_o = 1.
- STALL_TIMEOUT = 8; hold stallreq_i[2] = 1 for 8 cycles -> wdog_o = 1 after the 8th edge. Pulse wdog_clr_i -> wdog_o = 0. Stall_cnt_o = 8 before the clear and keeps counting.
- Drop rst to 0 on the 2nd cycle of a 3-cycle flush -> all outputs are 0 immediately. After release, flush_o = 0 with excepttype_i = 0.
